sram_controller: RTL and testbench
==================================

// Module: sram_controller
// PURPOSE
//  Sits downstream of the cache controller and serves its line-fill reads and write-through writes.
//  Talks to the external 16-bit asynchronous SRAM.
//  - Read: fetches one 64-bit line as four halfword beats.
//  - Write: stores one 32-bit word as two halfword beats.
//  - Completion is signalled by a one-cycle sram_ready pulse.
// PARAMETERS
//  ACCESS_CYCLES  2   clock cycles each halfword beat holds address/data on the SRAM pins (>=1)
//  ADDR_W         18  SRAM halfword address width
// PORTS
//  clk         in   1   system clock, rising edge
//  rst         in   1   asynchronous, active-low reset
//  read        in   1   read-line request from cache (level, held until sram_ready)
//  write       in   1   write-word request from cache (level, held until sram_ready)
//  sram_adr    in   32  byte address; halfword base = sram_adr[ADDR_W:1]
//  sram_wdata  in   32  write data
//  sram_rdata  out  64  assembled line; halfword k in bits [16k+15:16k]
//  sram_ready  out  1   one-cycle completion pulse
//  SRAM_DQ     inout 16 SRAM data bus
//  SRAM_ADDR   out  18  SRAM halfword address
//  SRAM_WE_N   out  1   SRAM write enable, active low
//  SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  out 1  each tied 0
// BEHAVIOUR
//  Reset (async, rst=0), applied immediately, even mid-transaction:
//  - state IDLE; beat and wait counters 0
//  - sram_ready=0, sram_rdata=0, SRAM_ADDR=0, SRAM_WE_N=1, SRAM_DQ=Z; transaction aborted
//  FSM IDLE -> ACCESS -> DONE -> IDLE.
//  IDLE: on a clk edge with read|write=1, latch op, base address and wdata; go to ACCESS.
//  - write has priority if both are asserted.
//  ACCESS, read: BEATS=4.
//  - beat k drives SRAM_ADDR=base+k for ACCESS_CYCLES cycles
//  - SRAM_DQ sampled into sram_rdata[16k+15:16k] on the last cycle of the beat
//  ACCESS, write: BEATS=2.
//  - beat 0 drives wdata[15:0] at base; beat 1 drives wdata[31:16] at base+1
//  - SRAM_WE_N=0 and SRAM_DQ driven for the whole of every write beat; otherwise WE_N=1, DQ=Z
//  ACCESS exit: after the last cycle of the last beat, go to DONE.
//  DONE: sram_ready=1 for exactly this cycle; next state IDLE.
//  Latency: sram_ready rises BEATS*ACCESS_CYCLES+1 cycles after the accepting edge.
//  - read: 9 cycles at default; write: 5 cycles at default.
//  Request handling:
//  - Requests are latched, so deasserting read/write mid-ACCESS does not abort.
//  - New requests arriving during ACCESS or DONE are ignored.
//  - A request still high when IDLE is re-entered starts a new transaction.
//  sram_rdata: holds its value from DONE until the next read's beat 0 sample.
//  - It is not modified by writes.
//  Address arithmetic: base+k wraps modulo 2^ADDR_W; no carry into higher bits.
// CONFIGURATION
//  SRAM_CTRL_STATS_EN
//  - Defined: adds outputs rd_count[15:0] and wr_count[15:0], reset 0.
//  - Each counter increments in the DONE cycle of a read or write respectively.
//  - Counters saturate at 16'hFFFF.
//  - Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1. Read at sram_adr=32'h0000_0100; SRAM model returns 1111,2222,3333,4444 at addrs 0x80..0x83
//     -> sram_rdata=64'h4444_3333_2222_1111; sram_ready pulse 9 cycles after accept.
//  2. Write sram_adr=32'h0000_0204, wdata=32'hDEAD_BEEF -> SRAM[0x102]=BEEF, SRAM[0x103]=DEAD;
//     WE_N low for 2 cycles per beat; ready after 5 cycles.
//  3. read=write=1 together -> write performed; sram_rdata unchanged.
//  4. Drop read after 2 cycles -> all 4 beats still run; ready pulse still occurs.
//  5. rst=0 mid-write beat 1 -> WE_N=1 and DQ=Z immediately, state IDLE;
//     after release, a new read completes normally.
//  6. Base halfword 18'h3FFFE read -> addresses 3FFFE,3FFFF,00000,00001 issued.
//  With SRAM_CTRL_STATS_EN: 3 reads and 2 writes -> rd_count=3, wr_count=2.

Source files
------------

// File: rtl/sram_controller.sv
// Cache-side controller for a 16-bit asynchronous SRAM: 64-bit line reads (4 beats), 32-bit word writes (2 beats).
// Optional SRAM_CTRL_STATS_EN adds saturating read/write completion counters.
module sram_controller #(
   parameter int unsigned ACCESS_CYCLES = 2,
   parameter int unsigned ADDR_W        = 18
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       sram_adr,
   input  logic [31:0]       sram_wdata,
   output logic [63:0]       sram_rdata,
   output logic              sram_ready,
   inout  wire  [15:0]       SRAM_DQ,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic              SRAM_WE_N,
   output logic              SRAM_UB_N,
   output logic              SRAM_LB_N,
   output logic              SRAM_CE_N,
`ifdef SRAM_CTRL_STATS_EN
   output logic              SRAM_OE_N,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
`else
   output logic              SRAM_OE_N
`endif
);

   localparam int unsigned WAIT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t              state_q, state_d;
   logic                op_wr_q, op_wr_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [1:0]          beat_q, beat_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [63:0]         rdata_q, rdata_d;
   logic                ready_q, ready_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_n_q, we_n_d;
   logic                dq_oe_q, dq_oe_d;
   logic [15:0]         dq_out_q, dq_out_d;
   logic                beat_end_c;
   logic                last_beat_c;
   logic                unused_adr_c;
`ifdef SRAM_CTRL_STATS_EN
   logic [15:0]         rd_count_q, rd_count_d;
   logic [15:0]         wr_count_q, wr_count_d;
`endif

   assign unused_adr_c = ^{sram_adr[31:ADDR_W+1], sram_adr[0]};

   // Next-state, pin and datapath logic
   always_comb begin
      state_d     = state_q;
      op_wr_d     = op_wr_q;
      base_d      = base_q;
      wdata_d     = wdata_q;
      beat_d      = beat_q;
      wait_d      = wait_q;
      rdata_d     = rdata_q;
      ready_d     = 1'b0;
      addr_d      = addr_q;
      we_n_d      = 1'b1;
      dq_oe_d     = 1'b0;
      dq_out_d    = dq_out_q;
      beat_end_c  = (wait_q == WAIT_W'(ACCESS_CYCLES - 1));
      last_beat_c = op_wr_q ? (beat_q == 2'd1) : (beat_q == 2'd3);
`ifdef SRAM_CTRL_STATS_EN
      rd_count_d  = rd_count_q;
      wr_count_d  = wr_count_q;
`endif
      case (state_q)
         IDLE: begin
            if (read || write) begin
               state_d = ACCESS;
               op_wr_d = write;
               base_d  = sram_adr[ADDR_W:1];
               wdata_d = sram_wdata;
               beat_d  = 2'd0;
               wait_d  = '0;
               addr_d  = sram_adr[ADDR_W:1];
               if (write) begin
                  we_n_d   = 1'b0;
                  dq_oe_d  = 1'b1;
                  dq_out_d = sram_wdata[15:0];
               end
            end
         end
         ACCESS: begin
            if (beat_end_c) begin
               wait_d = '0;
               if (!op_wr_q) begin
                  rdata_d[{beat_q, 4'b0000} +: 16] = SRAM_DQ;
               end
               if (last_beat_c) begin
                  state_d = DONE;
               end else begin
                  beat_d = beat_q + 2'd1;
                  addr_d = base_q + ADDR_W'(beat_q) + ADDR_W'(1);
                  if (op_wr_q) begin
                     we_n_d   = 1'b0;
                     dq_oe_d  = 1'b1;
                     dq_out_d = wdata_q[31:16];
                  end
               end
            end else begin
               wait_d  = wait_q + WAIT_W'(1);
               we_n_d  = we_n_q;
               dq_oe_d = dq_oe_q;
            end
         end
         DONE: begin
            ready_d = 1'b1;
            state_d = IDLE;
`ifdef SRAM_CTRL_STATS_EN
            if (op_wr_q) begin
               if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
            end else begin
               if (rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         op_wr_q    <= 1'b0;
         base_q     <= '0;
         wdata_q    <= '0;
         beat_q     <= '0;
         wait_q     <= '0;
         rdata_q    <= '0;
         ready_q    <= 1'b0;
         addr_q     <= '0;
         we_n_q     <= 1'b1;
         dq_oe_q    <= 1'b0;
         dq_out_q   <= '0;
`ifdef SRAM_CTRL_STATS_EN
         rd_count_q <= '0;
         wr_count_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         op_wr_q    <= op_wr_d;
         base_q     <= base_d;
         wdata_q    <= wdata_d;
         beat_q     <= beat_d;
         wait_q     <= wait_d;
         rdata_q    <= rdata_d;
         ready_q    <= ready_d;
         addr_q     <= addr_d;
         we_n_q     <= we_n_d;
         dq_oe_q    <= dq_oe_d;
         dq_out_q   <= dq_out_d;
`ifdef SRAM_CTRL_STATS_EN
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
`endif
      end
   end

   assign SRAM_DQ    = dq_oe_q ? dq_out_q : 16'bz;
   assign SRAM_ADDR  = addr_q;
   assign SRAM_WE_N  = we_n_q;
   assign SRAM_UB_N  = 1'b0;
   assign SRAM_LB_N  = 1'b0;
   assign SRAM_CE_N  = 1'b0;
   assign SRAM_OE_N  = 1'b0;
   assign sram_rdata = rdata_q;
   assign sram_ready = ready_q;
`ifdef SRAM_CTRL_STATS_EN
   assign rd_count   = rd_count_q;
   assign wr_count   = wr_count_q;
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural async SRAM and an expected-completion queue.
module tb_sram_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        read, write;
   logic [31:0] sram_adr, sram_wdata;
   logic [63:0] sram_rdata;
   logic        sram_ready;
   wire  [15:0] SRAM_DQ;
   logic [17:0] SRAM_ADDR;
   logic        SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N;
`ifdef SRAM_CTRL_STATS_EN
   logic [15:0] rd_count, wr_count;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [63:0] rdata;
      int          lat;
      string       tag;
   } exp_t;
   exp_t sb[$];

   logic [15:0] mem [0:262143];
   logic [17:0] addr_log [0:63];
   logic        we_log   [0:63];
   int          last_lat;

   sram_controller dut (
      .clk(clk), .rst(rst), .read(read), .write(write),
      .sram_adr(sram_adr), .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata), .sram_ready(sram_ready),
      .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N),
      .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N), .SRAM_CE_N(SRAM_CE_N),
`ifdef SRAM_CTRL_STATS_EN
      .SRAM_OE_N(SRAM_OE_N), .rd_count(rd_count), .wr_count(wr_count)
`else
      .SRAM_OE_N(SRAM_OE_N)
`endif
   );

   always #5 clk = ~clk;

   // Asynchronous SRAM: drives data while not writing, captures while WE_N is low
   assign SRAM_DQ = SRAM_WE_N ? mem[SRAM_ADDR] : 16'bz;
   always @(negedge clk) begin
      if (!SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start(input bit rd, input bit wr, input logic [31:0] adr,
                        input logic [31:0] wd, input logic [63:0] exp_rd,
                        input int exp_lat, input string tag);
      exp_t e;
      @(negedge clk);
      read       = rd;
      write      = wr;
      sram_adr   = adr;
      sram_wdata = wd;
      e.rdata = exp_rd;
      e.lat   = exp_lat;
      e.tag   = tag;
      sb.push_back(e);
   endtask

   // Waits for completion (bounded), logs pins each cycle, scores against the queue head
   task automatic finish_txn(input int drop_c);
      bit   got;
      exp_t e;
      got      = 1'b0;
      last_lat = -1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         addr_log[i] = SRAM_ADDR;
         we_log[i]   = SRAM_WE_N;
         if (i == drop_c) begin
            read  = 1'b0;
            write = 1'b0;
         end
         if (sram_ready) begin
            got      = 1'b1;
            last_lat = i;
            break;
         end
      end
      read  = 1'b0;
      write = 1'b0;
      e = sb.pop_front();
      if (!got) begin
         chk({e.tag, "_timeout"}, 64'd0, 64'd1);
      end else begin
         chk({e.tag, "_lat"}, 64'(last_lat), 64'(e.lat));
         chk({e.tag, "_rdata"}, sram_rdata, e.rdata);
         @(posedge clk);
         #1;
         chk({e.tag, "_pulse_width"}, 64'(sram_ready), 64'd0);
      end
   endtask

   initial begin
      int we_low;
      logic [63:0] line1;
      line1 = 64'h4444_3333_2222_1111;
      read = 1'b0; write = 1'b0; sram_adr = '0; sram_wdata = '0;
      rst = 1'b1;
      mem[18'h00080] = 16'h1111; mem[18'h00081] = 16'h2222;
      mem[18'h00082] = 16'h3333; mem[18'h00083] = 16'h4444;
      mem[18'h00200] = 16'hAAAA; mem[18'h00201] = 16'hBBBB;
      mem[18'h00202] = 16'hCCCC; mem[18'h00203] = 16'hDDDD;
      mem[18'h3FFFE] = 16'hA0A0; mem[18'h3FFFF] = 16'hB1B1;
      mem[18'h00000] = 16'hC2C2; mem[18'h00001] = 16'hD3D3;
      #2 rst = 1'b0;
      #20;
      chk("rst_ready", 64'(sram_ready), 64'd0);
      chk("rst_rdata", sram_rdata, 64'd0);
      chk("rst_addr", 64'(SRAM_ADDR), 64'd0);
      chk("rst_we_n", 64'(SRAM_WE_N), 64'd1);
      chk("tied_pins", 64'({SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N}), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // Line read of halfwords 0x80..0x83
      start(1'b1, 1'b0, 32'h0000_0100, 32'h0, line1, 9, "rd1");
      finish_txn(99);
      chk("rd1_addr_b0", 64'(addr_log[0]), 64'h80);
      chk("rd1_addr_b3", 64'(addr_log[6]), 64'h83);

      // Word write: low half at base, high half at base+1
      start(1'b0, 1'b1, 32'h0000_0204, 32'hDEAD_BEEF, line1, 5, "wr1");
      finish_txn(99);
      we_low = 0;
      for (int i = 0; i < 5; i++) if (we_log[i] == 1'b0) we_low++;
      chk("wr1_we_low_cycles", 64'(we_low), 64'd4);
      chk("wr1_mem_lo", 64'(mem[18'h102]), 64'hBEEF);
      chk("wr1_mem_hi", 64'(mem[18'h103]), 64'hDEAD);

      // Simultaneous read and write: write wins, line data untouched
      start(1'b1, 1'b1, 32'h0000_0300, 32'h1234_5678, line1, 5, "both");
      finish_txn(99);
      chk("both_mem_lo", 64'(mem[18'h180]), 64'h5678);
      chk("both_mem_hi", 64'(mem[18'h181]), 64'h1234);

      // Request dropped early still completes all beats
      start(1'b1, 1'b0, 32'h0000_0400, 32'h0, 64'hDDDD_CCCC_BBBB_AAAA, 9, "drop");
      finish_txn(2);

      // Reset during write beat 1
      start(1'b0, 1'b1, 32'h0000_0500, 32'hCAFE_F00D, 64'd0, 5, "abort");
      repeat (4) @(posedge clk);
      #1;
      chk("abort_pre_we_n", 64'(SRAM_WE_N), 64'd0);
      chk("abort_pre_addr", 64'(SRAM_ADDR), 64'h281);
      rst   = 1'b0;
      write = 1'b0;
      #1;
      chk("abort_we_n", 64'(SRAM_WE_N), 64'd1);
      chk("abort_addr", 64'(SRAM_ADDR), 64'd0);
      chk("abort_rdata", sram_rdata, 64'd0);
      chk("abort_ready", 64'(sram_ready), 64'd0);
      void'(sb.pop_front());
      @(negedge clk);
      rst = 1'b1;
      start(1'b1, 1'b0, 32'h0000_0100, 32'h0, line1, 9, "post_rst");
      finish_txn(99);

      // Halfword address wrap at the top of the SRAM
      start(1'b1, 1'b0, 32'h0007_FFFC, 32'h0, 64'hD3D3_C2C2_B1B1_A0A0, 9, "wrap");
      finish_txn(99);
      chk("wrap_a0", 64'(addr_log[0]), 64'h3FFFE);
      chk("wrap_a1", 64'(addr_log[2]), 64'h3FFFF);
      chk("wrap_a2", 64'(addr_log[4]), 64'h00000);
      chk("wrap_a3", 64'(addr_log[6]), 64'h00001);

`ifdef SRAM_CTRL_STATS_EN
      chk("stats_rd", 64'(rd_count), 64'd2);
      chk("stats_wr", 64'(wr_count), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
